// File: rtl/student_alu_pkg.sv
// Shared definitions for the pipelined Hack-style ALU: control-bit positions,
// the packed control word and the encodings of the 18 standard Hack functions.
package student_alu_pkg;

  // Bit positions inside a 6-bit Hack control word {zx,nx,zy,ny,f,no}.
  localparam int ZX = 5;
  localparam int NX = 4;
  localparam int ZY = 3;
  localparam int NY = 2;
  localparam int F  = 1;
  localparam int NO = 0;

  localparam int NUM_OPS = 18;

  typedef logic [5:0] hack_op_t;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } hack_ctrl_t;

  localparam hack_op_t OP_ZERO    = 6'b101010;
  localparam hack_op_t OP_ONE     = 6'b111111;
  localparam hack_op_t OP_NEG_ONE = 6'b111010;
  localparam hack_op_t OP_X       = 6'b001100;
  localparam hack_op_t OP_Y       = 6'b110000;
  localparam hack_op_t OP_NOT_X   = 6'b001101;
  localparam hack_op_t OP_NOT_Y   = 6'b110001;
  localparam hack_op_t OP_NEG_X   = 6'b001111;
  localparam hack_op_t OP_NEG_Y   = 6'b110011;
  localparam hack_op_t OP_XPLUS1  = 6'b011111;
  localparam hack_op_t OP_YPLUS1  = 6'b110111;
  localparam hack_op_t OP_XMINUS1 = 6'b001110;
  localparam hack_op_t OP_YMINUS1 = 6'b110010;
  localparam hack_op_t OP_XPLUSY  = 6'b000010;
  localparam hack_op_t OP_XMINUSY = 6'b010011;
  localparam hack_op_t OP_YMINUSX = 6'b000111;
  localparam hack_op_t OP_XANDY   = 6'b000000;
  localparam hack_op_t OP_XORY    = 6'b010101;

  function automatic hack_ctrl_t decode_op(input hack_op_t op);
    return hack_ctrl_t'(op);
  endfunction

endpackage

// File: rtl/student_alu_core.sv
// Combinational second stage: add/and of preconditioned operands, optional
// output negation, and the zero/negative/carry/overflow flags.
module student_alu_core
  import student_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_xp,
  input  logic [WIDTH-1:0] i_yp,
  input  logic             i_f,
  input  logic             i_no,
  output logic [WIDTH-1:0] o_out,
  output logic             o_zr,
  output logic             o_ng,
  output logic             o_cy,
  output logic             o_ov
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_r;

  assign w_sum = {1'b0, i_xp} + {1'b0, i_yp};
  assign w_r   = i_f ? w_sum[WIDTH-1:0] : (i_xp & i_yp);
  assign o_out = i_no ? ~w_r : w_r;

  // Carry/overflow describe the adder itself, so they ignore the output negation.
  assign o_cy = i_f & w_sum[WIDTH];
  assign o_ov = i_f & (i_xp[WIDTH-1] == i_yp[WIDTH-1])
                    & (w_sum[WIDTH-1] != i_xp[WIDTH-1]);

  assign o_zr = (o_out == '0);
  assign o_ng = o_out[WIDTH-1];

endmodule

// File: rtl/student_alu_pipe.sv
// Two-stage pipelined Hack ALU with valid/ready on both sides and an
// accumulator operand mode (X := previous result).
module student_alu_pipe
  import student_alu_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             acc_sel,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cy,
  output logic             ov
);

  function automatic logic [WIDTH-1:0] precond(input logic [WIDTH-1:0] v,
                                               input logic z, input logic n);
    logic [WIDTH-1:0] t;
    t = z ? '0 : v;
    return n ? ~t : t;
  endfunction

  hack_ctrl_t       w_ctrl;
  logic [WIDTH-1:0] w_xa;
  logic [WIDTH-1:0] w_xp_in;
  logic [WIDTH-1:0] w_yp_in;
  logic             w_out_ld;
  logic             w_s1_free;
  logic             w_accept;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_xp;
  logic [WIDTH-1:0] r_yp;
  logic             r_f;
  logic             r_no;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out;
  logic             r_zr;
  logic             r_ng;
  logic             r_cy;
  logic             r_ov;
  logic [WIDTH-1:0] r_acc;

  logic [WIDTH-1:0] w_core_out;
  logic             w_core_zr;
  logic             w_core_ng;
  logic             w_core_cy;
  logic             w_core_ov;

  assign w_ctrl  = decode_op({zx, nx, zy, ny, f, no});
  assign w_xa    = acc_sel ? r_acc : x;
  assign w_xp_in = precond(w_xa, w_ctrl.zx, w_ctrl.nx);
  assign w_yp_in = precond(y, w_ctrl.zy, w_ctrl.ny);

  // An accumulator op must see the result of everything already accepted, so it
  // waits until stage 1 has drained into the output register (one bubble).
  assign w_out_ld  = r_s1_valid & (~r_out_valid | out_ready);
  assign w_s1_free = ~r_s1_valid | w_out_ld;
  assign in_ready  = w_s1_free & ~(acc_sel & r_s1_valid);
  assign w_accept  = in_valid & in_ready;

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_xp       <= '0;
      r_yp       <= '0;
      r_f        <= 1'b0;
      r_no       <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_xp       <= w_xp_in;
      r_yp       <= w_yp_in;
      r_f        <= w_ctrl.f;
      r_no       <= w_ctrl.no;
    end else if (w_out_ld) begin
      r_s1_valid <= 1'b0;
    end
  end

  student_alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_xp  (r_xp),
    .i_yp  (r_yp),
    .i_f   (r_f),
    .i_no  (r_no),
    .o_out (w_core_out),
    .o_zr  (w_core_zr),
    .o_ng  (w_core_ng),
    .o_cy  (w_core_cy),
    .o_ov  (w_core_ov)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_zr        <= 1'b0;
      r_ng        <= 1'b0;
      r_cy        <= 1'b0;
      r_ov        <= 1'b0;
      r_acc       <= ACC_INIT;
    end else if (w_out_ld) begin
      r_out_valid <= 1'b1;
      r_out       <= w_core_out;
      r_zr        <= w_core_zr;
      r_ng        <= w_core_ng;
      r_cy        <= w_core_cy;
      r_ov        <= w_core_ov;
      r_acc       <= w_core_out;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign zr        = r_zr;
  assign ng        = r_ng;
  assign cy        = r_cy;
  assign ov        = r_ov;

endmodule

// File: tb/tb_student_alu_pipe.sv
// Self-checking bench for student_alu_pipe: directed Hack-function tests plus
// randomized traffic scored against an arithmetic reference model.
module tb_student_alu_pipe;
  import student_alu_pkg::*;

  localparam int W = 16;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] x         = '0;
  logic [W-1:0] y         = '0;
  logic         acc_sel   = 1'b0;
  logic         zx = 1'b0, nx = 1'b0, zy = 1'b0, ny = 1'b0, f = 1'b0, no = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out;
  logic         zr, ng, cy, ov;

  always #5 clk = ~clk;

  student_alu_pipe #(
    .WIDTH    (W),
    .ACC_INIT (16'h0000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .acc_sel   (acc_sel),
    .zx        (zx),
    .nx        (nx),
    .zy        (zy),
    .ny        (ny),
    .f         (f),
    .no        (no),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zr        (zr),
    .ng        (ng),
    .cy        (cy),
    .ov        (ov)
  );

  typedef struct {
    logic [15:0] out;
    logic        zr, ng, cy, ov;
  } res_t;

  res_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          inflight = 0;
  logic [15:0] m_acc = 16'h0000;
  bit          last_accept = 0;
  bit          prev_accept = 0;
  bit          rand_ready = 0;
  int          stall_lo = -1;
  int          stall_hi = -1;
  bit          hold_prev = 0;
  logic [19:0] hold_val = '0;
  bit          saw_block = 0;
  logic [15:0] last_out = '0;

  hack_op_t ops [NUM_OPS] = '{OP_ZERO, OP_ONE, OP_NEG_ONE, OP_X, OP_Y, OP_NOT_X,
                              OP_NOT_Y, OP_NEG_X, OP_NEG_Y, OP_XPLUS1, OP_YPLUS1,
                              OP_XMINUS1, OP_YMINUS1, OP_XPLUSY, OP_XMINUSY,
                              OP_YMINUSX, OP_XANDY, OP_XORY};
  logic [15:0] t3_exp [NUM_OPS] = '{16'd0, 16'd1, 16'hFFFF, 16'd17, 16'd3, 16'hFFEE,
                                    16'hFFFC, 16'hFFEF, 16'hFFFD, 16'd18, 16'd4,
                                    16'd16, 16'd2, 16'd20, 16'd14, 16'hFFF2,
                                    16'd1, 16'd19};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: Hack rules in plain integer arithmetic (~v == 65535 - v).
  function automatic res_t ref_alu(input logic [15:0] xa, input logic [15:0] ya,
                                   input hack_op_t op);
    res_t        r;
    int unsigned xv, yv, usum, rv;
    int          sx, sy, ssum;
    xv = op[ZX] ? 0 : int'(xa);
    if (op[NX]) xv = 65535 - xv;
    yv = op[ZY] ? 0 : int'(ya);
    if (op[NY]) yv = 65535 - yv;
    r.cy = 1'b0;
    r.ov = 1'b0;
    if (op[F]) begin
      usum = xv + yv;
      r.cy = (usum > 65535);
      rv   = usum % 65536;
      sx   = (xv >= 32768) ? int'(xv) - 65536 : int'(xv);
      sy   = (yv >= 32768) ? int'(yv) - 65536 : int'(yv);
      ssum = sx + sy;
      r.ov = (ssum > 32767) || (ssum < -32768);
    end else begin
      rv = xv & yv;
    end
    if (op[NO]) rv = 65535 - rv;
    r.out = 16'(rv);
    r.zr  = (rv == 0);
    r.ng  = (rv >= 32768);
    return r;
  endfunction

  // One clock cycle: entered and left at posedge+1.
  task automatic step();
    res_t e;
    out_ready = rand_ready ? 1'($urandom_range(0, 3) != 0)
                           : !(cyc >= stall_lo && cyc <= stall_hi);
    @(negedge clk);
    if (hold_prev) check("stall_hold", {out, zr, ng, cy, ov}, hold_val);
    hold_prev = out_valid && !out_ready;
    hold_val  = {out, zr, ng, cy, ov};
    if (in_valid) begin
      if (!acc_sel) check("in_ready_capacity", in_ready, (inflight < 2) || out_ready);
      else if (prev_accept) check("in_ready_acc_interlock", in_ready, 0);
      if (!in_ready) saw_block = 1;
    end
    last_accept = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("out", out, e.out);
        check("flags_zr_ng_cy_ov", {zr, ng, cy, ov}, {e.zr, e.ng, e.cy, e.ov});
        last_out = out;
        inflight--;
      end
    end
    if (last_accept) begin
      e = ref_alu(acc_sel ? m_acc : x, y, {zx, nx, zy, ny, f, no});
      exp_q.push_back(e);
      m_acc = e.out;
      inflight++;
    end
    prev_accept = last_accept;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic [15:0] xi, input logic [15:0] yi, input bit acc,
                       input hack_op_t op, output int waits);
    x = xi;
    y = yi;
    acc_sel = acc;
    {zx, nx, zy, ny, f, no} = op;
    in_valid = 1'b1;
    waits = 0;
    step();
    while (!last_accept && waits < 20) begin
      waits++;
      step();
    end
    if (!last_accept) check("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    int k;
    in_valid = 1'b0;
    acc_sel  = 1'b0;
    k = 0;
    while (exp_q.size() > 0 && k < 40) begin
      k++;
      step();
    end
    check("drain_all_results", exp_q.size(), 0);
  endtask

  task automatic run_one(input logic [15:0] xi, input logic [15:0] yi, input hack_op_t op,
                         output logic [15:0] o, output logic [3:0] fl);
    int w, k;
    issue(xi, yi, 1'b0, op, w);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 5) begin
      k++;
      step();
    end
    if (!out_valid) check("result_timeout", 0, 1);
    o  = out;
    fl = {zr, ng, cy, ov};
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    acc_sel  = 1'b0;
    rst_n    = 1'b0;
    #2;
    check("reset_out_valid", out_valid, 0);
    check("reset_out", out, 0);
    check("reset_flags", {zr, ng, cy, ov}, 0);
    check("reset_in_ready", in_ready, 1);
    exp_q.delete();
    inflight    = 0;
    m_acc       = 16'h0000;
    hold_prev   = 0;
    prev_accept = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int          w;
    logic [15:0] o;
    logic [3:0]  fl;

    @(posedge clk);
    #1;
    do_reset();

    // Accumulator chain straight out of reset: x := acc, acc+1 four times.
    for (int i = 0; i < 4; i++) begin
      issue(16'h0000, 16'h0001, 1'b1, OP_XPLUSY, w);
      if (i > 0) check("acc_one_bubble", w, 1);
    end
    drain();
    check("acc_chain_final", last_out, 16'd4);

    // 5 + 3 with latency observation.
    issue(16'd5, 16'd3, 1'b0, OP_XPLUSY, w);
    in_valid = 1'b0;
    check("t1_not_valid_after_accept", out_valid, 0);
    step();
    check("t1_valid", out_valid, 1);
    check("t1_out", out, 16'd8);
    check("t1_flags", {zr, ng, cy, ov}, 4'b0000);
    drain();

    // Overflow and carry boundaries.
    run_one(16'h7FFF, 16'h0001, OP_XPLUSY, o, fl);
    check("t2_ovf_out", o, 16'h8000);
    check("t2_ovf_flags", fl, 4'b0101);
    run_one(16'hFFFF, 16'h0001, OP_XPLUSY, o, fl);
    check("t2_carry_out", o, 16'h0000);
    check("t2_carry_flags", fl, 4'b1010);
    drain();

    // Full Hack function table with x=17, y=3.
    for (int i = 0; i < NUM_OPS; i++) begin
      run_one(16'd17, 16'd3, ops[i], o, fl);
      check($sformatf("t3_op%0d", i), o, t3_exp[i]);
    end
    drain();

    // Eight back-to-back random ops with a three-cycle consumer stall.
    stall_lo  = cyc + 3;
    stall_hi  = cyc + 5;
    saw_block = 0;
    for (int i = 0; i < 8; i++)
      issue(16'($urandom), 16'($urandom), 1'b0, ops[$urandom_range(0, NUM_OPS - 1)], w);
    drain();
    stall_lo = -1;
    stall_hi = -1;
    check("t4_in_ready_dropped", saw_block, 1);

    // Randomized traffic: mixed accumulator ops and random backpressure.
    rand_ready = 1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        in_valid = 1'b0;
        step();
      end
      issue(16'($urandom), 16'($urandom), 1'($urandom_range(0, 3) == 0),
            ops[$urandom_range(0, NUM_OPS - 1)], w);
    end
    drain();
    rand_ready = 0;

    // Reset with two ops in flight, then a clean op.
    issue(16'd100, 16'd1, 1'b0, OP_XPLUSY, w);
    issue(16'd200, 16'd2, 1'b0, OP_XMINUSY, w);
    do_reset();
    step();
    check("t6_no_stale_output", out_valid, 0);
    issue(16'd5, 16'd3, 1'b0, OP_XPLUSY, w);
    in_valid = 1'b0;
    check("t6_not_valid_after_accept", out_valid, 0);
    step();
    check("t6_out", out, 16'd8);
    check("t6_flags", {zr, ng, cy, ov}, 4'b0000);
    issue(16'h1234, 16'h0000, 1'b1, OP_X, w);
    drain();
    check("t6_acc_after_reset_chain", last_out, 16'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
